// File: rtl/bch_decode_arbiter.sv
`timescale 1ns/1ps
// Arbitrates whole codewords from NREQ sources into one shared BCH decode chain and routes
// Chien output back to each word's owner via a tag FIFO. Define BCH_ARB_FIXED_PRIO_EN for fixed priority.

module bch_decode_arbiter #(
    parameter int NREQ       = 4,
    parameter int BITS       = 1,
    parameter int BEATS      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*BITS-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 syn_start,
    output logic                 syn_ce,
    output logic [BITS-1:0]      syn_data,
    input  logic                 syn_ready,
    input  logic                 syn_done,
    input  logic                 key_ready,
    input  logic                 err_first,
    input  logic                 err_valid,
    input  logic                 err_last,
    input  logic [BITS-1:0]      err,
    output logic [NREQ-1:0]      rsp_valid,
    output logic                 rsp_first,
    output logic                 rsp_last,
    output logic [BITS-1:0]      rsp_err,
    output logic                 busy,
    output logic                 tag_underflow
);

    localparam int TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state_q, state_d;
    logic [TAG_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] search_base;

    logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    logic [NREQ-1:0]  rsp_valid_q;
    logic             rsp_first_q, rsp_last_q, drop_q, underflow_q;
    logic [BITS-1:0]  rsp_err_q;
    logic [TAG_W-1:0] rsp_tag_q;

    logic             stage_ce, syn_ce_int, grant, any_valid, fifo_full, fifo_empty;
    logic             push, pop, cur_drop;
    logic [TAG_W-1:0] winner, sel, cur_tag;
    logic [BITS-1:0]  sel_data;

`ifdef BCH_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [TAG_W-1:0] rr_q, rr_d;
    assign search_base = rr_q;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid requester at or after the search base, wrapping modulo NREQ.
    always_comb begin : pick
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(search_base) + k) % NREQ;
            if (!any_valid && req_valid[TAG_W'(idx)]) begin
                winner    = TAG_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign sel = (state_q == IDLE) ? winner : owner_q;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (sel == TAG_W'(i)) sel_data = req_data[i*BITS +: BITS];
    end

    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign stage_ce   = !syn_done || key_ready;
    assign syn_ce_int = stage_ce && ((state_q == IDLE) || req_valid[owner_q]);
    assign grant      = !reset && (state_q == IDLE) && any_valid && syn_ready && !fifo_full && stage_ce;
    assign push       = grant;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
`ifndef BCH_ARB_FIXED_PRIO_EN
        rr_d      = rr_q;
`endif
        req_ready = '0;
        syn_start = 1'b0;
        syn_ce    = 1'b0;
        syn_data  = '0;
        if (!reset) begin
            syn_ce = syn_ce_int;
            case (state_q)
                IDLE: if (grant) begin
                    req_ready[winner] = 1'b1;
                    syn_start         = 1'b1;
                    syn_data          = sel_data;
                    owner_d           = winner;
`ifndef BCH_ARB_FIXED_PRIO_EN
                    rr_d = (winner == TAG_W'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif
                    if (BEATS > 1) begin
                        cnt_d   = CNT_W'(1);
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    syn_data = sel_data;
                    // A stalled owner freezes the syndrome stage; the counter simply holds.
                    if (syn_ce_int) begin
                        req_ready[owner_q] = 1'b1;
                        if (cnt_q == CNT_W'(BEATS - 1)) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // The owner tag is sampled from the FIFO head on err_first and held for the rest of the word.
    assign cur_tag  = err_first ? tag_mem[rd_ptr_q] : rsp_tag_q;
    assign cur_drop = err_first ? fifo_empty : drop_q;
    assign pop      = err_last && !cur_drop;

    // NOTE: tag storage carries no reset; validity is tracked solely by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr_q] <= winner;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            cnt_q       <= '0;
`ifndef BCH_ARB_FIXED_PRIO_EN
            rr_q        <= '0;
`endif
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rsp_valid_q <= '0;
            rsp_first_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= '0;
            rsp_tag_q   <= '0;
            drop_q      <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
`ifndef BCH_ARB_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;

            rsp_valid_q <= ((err_valid || err_first) && !cur_drop) ? (NREQ'(1) << cur_tag) : '0;
            rsp_first_q <= err_first;
            rsp_last_q  <= err_last;
            rsp_err_q   <= err;
            if (err_first) begin
                rsp_tag_q <= cur_tag;
                drop_q    <= fifo_empty;
                if (fifo_empty) underflow_q <= 1'b1;
            end
            if (err_last) drop_q <= 1'b1;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_first     = rsp_first_q;
    assign rsp_last      = rsp_last_q;
    assign rsp_err       = rsp_err_q;
    assign tag_underflow = underflow_q;
    assign busy          = (state_q == STREAM) || (level_q != '0);

endmodule

// File: doc/bch_decode_arbiter.md
Name: bch_decode_arbiter

Overview:
Shares one BCH decode pipeline (syndrome → key solver → Chien search) between NREQ codeword requesters. The block grants whole codewords round-robin, drives the syndrome stage's start/ce/data, and records each grant's owner in a tag FIFO. Chien error output is then routed back to the requester that owns it. It sits between the per-channel codeword sources and the shared bch_syndrome/bch_sigma_*/bch_error_* chain.

Parameters:
NREQ, 4, number of requesters (≥2)
BITS, 1, data beat width; must match the decode chain's BITS
BEATS, 16, beats per codeword (code bits / BITS)
FIFO_DEPTH, 4, max codewords in flight past the syndrome input (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req_valid  in  NREQ  per-requester beat valid
req_data  in  NREQ*BITS  per-requester beat, requester i at [i*BITS+:BITS]
req_ready  out  NREQ  beat accepted for requester i (one-hot or zero)
syn_start  out  1  syndrome start; high on the first beat of a word
syn_ce  out  1  syndrome clock enable
syn_data  out  BITS  beat to syndrome
syn_ready  in  1  syndrome stage can accept start
syn_done  in  1  syndromes complete
key_ready  in  1  key solver can accept
err_first  in  1  Chien first beat
err_valid  in  1  Chien beat valid (first through last)
err_last  in  1  Chien last beat
err  in  BITS  Chien error bits
rsp_valid  out  NREQ  one-hot owner of the current response beat
rsp_first  out  1  first response beat
rsp_last  out  1  last response beat
rsp_err  out  BITS  error bits
busy  out  1  word streaming or tag FIFO non-empty
tag_underflow  out  1  sticky: Chien output arrived with the tag FIFO empty

Behaviour:
- Reset: state IDLE, RR pointer 0, beat counter 0, FIFO empty; all outputs 0, including tag_underflow.
- stage_ce = !syn_done || key_ready. syn_ce = stage_ce && (state==IDLE || req_valid[owner]).
  - A requester that drops valid mid-word freezes the syndrome stage. The requester must not abandon a word once granted.
- IDLE:
  - Grant when any req_valid, syn_ready, FIFO not full and stage_ce.
  - Winner is the first valid index starting at the RR pointer, wrapping modulo NREQ.
  - In the same cycle: req_ready[winner]=1, syn_start=1, syn_data=req_data[winner], tag pushed, owner latched, beat counter=1, RR pointer=winner+1 mod NREQ.
  - If BEATS==1, stay IDLE; otherwise go to STREAM.
- STREAM:
  - req_ready[owner]=syn_ce, syn_data=req_data[owner], syn_start=0. Counter increments per accepted beat.
  - On the accepted beat with counter==BEATS-1 → IDLE.
  - A new grant may occur the cycle after the last beat; there is no bubble requirement.
  - Other requesters see req_ready=0.
- Response path:
  - 1-cycle registered: rsp_valid[head_tag]=err_valid|err_first, rsp_first, rsp_last and rsp_err mirror the inputs of the previous cycle.
  - The head tag is read when err_first is seen and held until err_last.
  - Pop on err_last.
  - No backpressure on the response path.
- Underflow: err_first with FIFO empty sets tag_underflow and suppresses all rsp_valid for that word. The flag clears only on reset.
- FIFO full: no grant. Push and pop in the same cycle are legal when not full; the count is unchanged.
- busy = (state==STREAM) || FIFO count != 0.
- Reset mid-word or mid-response: immediate return to reset state. In-flight tags are discarded; the downstream chain is reset by the same reset.

Optional Feature:
BCH_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest valid index wins. The RR pointer is removed.
- Undefined: round-robin as above.

Test Plan:
- NREQ=4, BEATS=16; only req 2 valid with a word containing errors at bits 3 and 9 → syn_start one cycle; 16 beats with req_ready=0100b; after the Chien output, rsp_valid=0100b for 16 beats with rsp_err set at beats 3 and 9; rsp_first/rsp_last on beats 0/15.
- All four requesters continuously valid → grant order 0,1,2,3,0 with back-to-back words. With BCH_ARB_FIXED_PRIO_EN the order is 0,0,0…
- FIFO_DEPTH=4, key_ready held low → after 4 grants no fifth syn_start and busy=1. Releasing key_ready resumes grants.
- Req 1 drops req_valid at beat 7 for 3 cycles → syn_ce=0 for those 3 cycles; beat counter holds at 7; the word completes with correct syndromes.
- err_first/err_valid/err_last pulsed with the FIFO empty → tag_underflow=1, rsp_valid stays 0000b. Reset clears the flag.
- Reset asserted at beat 5 of a word → next cycle: state IDLE, req_ready=0, busy=0, FIFO empty, RR pointer 0.
